// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache: same-cycle hits, single 4-word line refill on a miss.
// Optional hit/miss performance counters are enabled with `define ICACHE_PERF_CNT_EN.
module icache_direct #(
  parameter int NUM_BLOCKS = 8,
  parameter int INDEX_W    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic          proc_stall,
  output logic [31:0]   proc_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic          mem_ready,
  input  logic [127:0]  mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  localparam int TAG_W = 28 - INDEX_W;

  typedef enum logic {
    IDLE,
    ALLOC
  } state_t;

  state_t state, next_state;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [127:0]          data_mem [NUM_BLOCKS];

  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_index;
  logic [1:0]         addr_offset;
  logic               rd_req;
  logic               hit;
  logic               fill_en;

  assign addr_tag    = proc_addr[29:2+INDEX_W];
  assign addr_index  = proc_addr[1+INDEX_W:2];
  assign addr_offset = proc_addr[1:0];

  // A write request is handled exactly like an idle cycle.
  assign rd_req = proc_read & ~proc_write;
  assign hit    = rd_req & valid_q[addr_index] & (tag_mem[addr_index] == addr_tag);

  assign proc_rdata = data_mem[addr_index][{addr_offset, 5'b0} +: 32];
  assign mem_addr   = proc_addr[29:2];
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;
  assign fill_en    = (state == ALLOC) & mem_ready;

  logic unused_ok;
  assign unused_ok = ^{proc_wdata, 1'b0};

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    next_state = state;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_req && !hit) begin
          proc_stall = 1'b1;
          next_state = ALLOC;
        end
      end
      ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (mem_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= '0;
    end else begin
      state <= next_state;
      if (fill_en) valid_q[addr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      tag_mem[addr_index]  <= addr_tag;
      data_mem[addr_index] <= mem_rdata;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE) begin
      if (hit && hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      if (next_state == ALLOC && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: stimulus queues expected fetch words, a monitor checks served reads.
// Define ICACHE_PERF_CNT_EN to also check the performance counters.
module tb_icache_direct;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  icache_direct dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  localparam logic [127:0] LINE_A = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000013};
  localparam logic [127:0] LINE_B = {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000};
  localparam logic [127:0] LINE_C = {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
  localparam logic [127:0] LINE_D = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};
  localparam logic [127:0] LINE_S = {32'h66660003, 32'h66660002, 32'h66660001, 32'h66660000};
  localparam logic [127:0] LINE_E = {32'h77770003, 32'h77770002, 32'h77770001, 32'h77770000};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every served fetch must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && proc_read && !proc_write && !proc_stall) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", proc_rdata, 32'hxxxxxxxx);
      end else begin
        check("rdata", proc_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hit(input logic [29:0] a, input logic [31:0] exp_word);
    exp_q.push_back(exp_word);
    proc_addr = a;
    proc_read = 1'b1;
    @(negedge clk);
    check("hit_stall", {31'b0, proc_stall}, 32'd0);
    step();
    proc_read = 1'b0;
  endtask

  task automatic read_miss(input logic [29:0] a, input logic [127:0] line, input logic [31:0] exp_word);
    exp_q.push_back(exp_word);
    proc_addr = a;
    proc_read = 1'b1;
    @(negedge clk);
    check("miss_stall", {31'b0, proc_stall}, 32'd1);
    check("idle_mem_read", {31'b0, mem_read}, 32'd0);
    step();
    @(negedge clk);
    check("alloc_mem_read", {31'b0, mem_read}, 32'd1);
    check("alloc_mem_addr", {4'b0, mem_addr}, {4'b0, a[29:2]});
    check("alloc_stall", {31'b0, proc_stall}, 32'd1);
    step();
    mem_ready = 1'b1;
    mem_rdata = line;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("post_fill_stall", {31'b0, proc_stall}, 32'd0);
    step();
    proc_read = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", {31'b0, proc_stall}, 32'd0);
    check("reset_mem_read", {31'b0, mem_read}, 32'd0);
    check("mem_write_tied", {31'b0, mem_write}, 32'd0);
    check("mem_wdata_tied", mem_wdata[31:0] | mem_wdata[127:96], 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt_reset", hit_cnt, 32'd0);
    check("miss_cnt_reset", miss_cnt, 32'd0);
`endif
    step();

    // Cold miss on line 0, then hits on other words of it.
    read_miss(30'h0000000, LINE_A, 32'h00000013);
    read_hit(30'h0000003, 32'h33333333);
    read_hit(30'h0000001, 32'h11111111);
`ifdef ICACHE_PERF_CNT_EN
    @(negedge clk);
    check("miss_cnt", miss_cnt, 32'd1);
    check("hit_cnt", hit_cnt, 32'd3);
    step();
`endif

    // Conflict on index 0: tag B evicts tag A, which then misses again.
    read_miss(30'h0000020, LINE_B, 32'hDDDD0000);
    read_hit(30'h0000022, 32'hDDDD0002);
    read_miss(30'h0000000, LINE_A, 32'h00000013);

    // Another index leaves index 0 untouched.
    read_miss(30'h0000005, LINE_C, 32'h44440001);
    read_hit(30'h0000002, 32'h22222222);

    // proc_read drops during ALLOC: fill must still land.
    proc_addr = 30'h0000008;
    proc_read = 1'b1;
    @(negedge clk);
    check("drop_miss_stall", {31'b0, proc_stall}, 32'd1);
    step();
    proc_read = 1'b0;
    @(negedge clk);
    check("drop_alloc_mem_read", {31'b0, mem_read}, 32'd1);
    step();
    mem_ready = 1'b1;
    mem_rdata = LINE_D;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    read_hit(30'h000000B, 32'h55550003);

    // Reset in the middle of a fill, followed by a stray mem_ready.
    proc_addr = 30'h000000C;
    proc_read = 1'b1;
    @(negedge clk);
    check("rst_miss_stall", {31'b0, proc_stall}, 32'd1);
    step();
    @(negedge clk);
    check("rst_alloc_mem_read", {31'b0, mem_read}, 32'd1);
    step();
    rst       = 1'b1;
    proc_read = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_abort_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_abort_stall", {31'b0, proc_stall}, 32'd0);
    step();
    mem_ready = 1'b1;
    mem_rdata = LINE_S;
    step();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    check("stray_ready_mem_read", {31'b0, mem_read}, 32'd0);
    step();
    read_miss(30'h000000C, LINE_E, 32'h77770000);
    read_miss(30'h0000000, LINE_A, 32'h00000013);

    // Write requests are ignored: no stall, no memory traffic.
    proc_addr  = 30'h0000040;
    proc_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("write_stall", {31'b0, proc_stall}, 32'd0);
      check("write_mem_read", {31'b0, mem_read}, 32'd0);
      step();
    end
    proc_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rw_stall", {31'b0, proc_stall}, 32'd0);
      check("rw_mem_read", {31'b0, mem_read}, 32'd0);
      step();
    end
    proc_read  = 1'b0;
    proc_write = 1'b0;
    step();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipeline's fetch/alignment logic and the slow instruction memory.
- Serves 32-bit instruction words on a 30-bit word address.
- A hit returns data in the same cycle. A miss raises stall and refills one 4-word line from memory.
- Its processor-side ports connect directly to the core's ICACHE_* interface.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; must be a power of 2.
- INDEX_W, 3, log2(NUM_BLOCKS); tag width = 28 - INDEX_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- proc_read  input  1  fetch request.
- proc_write  input  1  write request; always ignored (read-only cache).
- proc_addr  input  30  word address: [29:2+INDEX_W] tag, [1+INDEX_W:2] index, [1:0] word offset.
- proc_wdata  input  32  unused.
- proc_stall  output  1  high while the request cannot be served this cycle.
- proc_rdata  output  32  selected word of the indexed line.
- mem_read  output  1  line-fill request.
- mem_write  output  1  tied 0.
- mem_addr  output  28  line address = proc_addr[29:2].
- mem_wdata  output  128  tied 0.
- mem_ready  input  1  one-cycle pulse; mem_rdata is valid in that cycle.
- mem_rdata  input  128  fill data; word0 in [31:0], word3 in [127:96].

Behaviour:
- Storage per line: valid bit, tag (28-INDEX_W bits), 128-bit data.
- hit = proc_read & valid[index] & (tag[index] == proc_addr tag field). Combinational.
- proc_rdata = data[index][32*offset +: 32], combinational at all times. The value is meaningful only when proc_stall = 0.
- Two-state FSM:
  - IDLE:
    - Hit, or proc_read = 0: proc_stall = 0 and the state stays IDLE.
    - proc_read & ~hit: proc_stall = 1 in the same cycle; next state is ALLOC.
  - ALLOC:
    - mem_read = 1, mem_addr = proc_addr[29:2], proc_stall = 1.
    - On a cycle with mem_ready = 1: write mem_rdata into the indexed line, set the tag, set valid = 1, go to IDLE.
    - In the next cycle the same address hits and proc_stall drops to 0.
- Miss latency: 1 cycle to enter ALLOC + memory latency + 1 cycle for the hit.
- mem_read is 0 in IDLE. mem_ready is sampled only in ALLOC and ignored in IDLE.
- The core holds proc_addr and proc_read stable while proc_stall = 1. The cache captures no address and always uses the live value.
- proc_read dropping during ALLOC: the fill still completes; no data is lost.
- Conflict miss: the line is overwritten. No write-back is ever performed.
- proc_write = 1: treated as proc_read = 0; no state change, no stall.
- Reset:
  - Clears all valid bits, FSM to IDLE, mem_read = 0, proc_stall = 0.
  - Tag and data arrays are not reset.
  - Reset during ALLOC abandons the fill; a later stray mem_ready has no effect.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- With the macro defined, two extra outputs are present: hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments once per IDLE cycle with hit = 1.
  - miss_cnt increments once per IDLE to ALLOC transition.
  - Both reset to 0, saturate at 0xFFFFFFFF, and are unaffected by stall cycles.
- Without the macro, neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then proc_read = 1, addr = 0x0000000 -> proc_stall = 1 the same cycle; next cycle mem_read = 1, mem_addr = 0x0000000.
- Cold fill: mem_ready pulse with mem_rdata = {D3,D2,D1,D0} = {0x33..,0x22..,0x11..,0x00000013} -> next cycle proc_stall = 0, proc_rdata = 0x00000013. Then addr = 0x0000003 -> no stall, proc_rdata = D3.
- Conflict: fill index 0 with tag A, then read addr with tag B at index 0 -> miss and refill. Re-read tag A -> misses again.
- Reset asserted mid-ALLOC, then mem_ready pulse -> mem_read = 0 immediately, no line updated, next read of that address misses.
- proc_write = 1, proc_read = 0 -> proc_stall = 0, mem_read stays 0 for 10 cycles.
- With ICACHE_PERF_CNT_EN: 1 cold miss + 3 hits -> miss_cnt = 1, hit_cnt = 3.
